cat_status_ctrl: RTL

//  Parametrised UART-command decoder and status register for the badge LED channels.
//  - Consumes decoded RX bytes through a valid/ready handshake.
//  - Maintains per-channel status and blink-enable bits.
//  - Drives a blinked LED vector for the top-level LED mux.
//  - Extends the single-byte set/clear scheme with:
//    - bulk commands;
//    - two-byte toggle and blink commands with argument timeout;
//    - an error pulse;
//    - a command counter.

---
 rtl/cat_cmd_pkg.sv | 56 +++++
 rtl/cat_status_ctrl_if.sv | 15 +
 rtl/tick_divider.sv | 31 +++
 rtl/cat_status_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cat_cmd_pkg.sv
// ---------------------------------------------------------------------------
// cat_cmd_pkg
//   Shared definitions for the badge LED command decoder:
//   - FSM state encoding for the command parser;
//   - ASCII command byte constants;
//   - decode_chan(): maps a received byte to a channel index plus a legal bit.
// ---------------------------------------------------------------------------
package cat_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARG_TOG = 2'd1,
        ST_ARG_BLK = 2'd2
    } cmd_state_e;

    localparam logic [7:0] CMD_ALL_SET = 8'h2A;  // '*'
    localparam logic [7:0] CMD_ALL_CLR = 8'h2D;  // '-'
    localparam logic [7:0] CMD_TOG     = 8'h7E;  // '~'
    localparam logic [7:0] CMD_BLK     = 8'h40;  // '@'
    localparam logic [7:0] CHR_UA      = 8'h41;  // 'A'
    localparam logic [7:0] CHR_LA      = 8'h61;  // 'a'
    localparam logic [7:0] CHR_CR      = 8'h0D;
    localparam logic [7:0] CHR_LF      = 8'h0A;

    // legal: byte is a letter whose index is below the channel count
    // upper: letter was upper case (clear command in IDLE)
    typedef struct packed {
        logic       legal;
        logic       upper;
        logic [4:0] idx;
    } chan_sel_t;

    function automatic chan_sel_t decode_chan(input logic [7:0] b, input int unsigned channels);
        chan_sel_t  s;
        logic [7:0] off_lo;
        logic [7:0] off_up;
        logic       is_lo;
        logic       is_up;
        // Bytes below the base wrap to large offsets, so one compare per case suffices.
        off_lo  = b - CHR_LA;
        off_up  = b - CHR_UA;
        is_lo   = (off_lo < 8'd26);
        is_up   = (off_up < 8'd26);
        s       = '0;
        s.upper = is_up;
        if (is_lo) begin
            s.idx   = off_lo[4:0];
            s.legal = ({24'd0, off_lo} < channels);
        end else if (is_up) begin
            s.idx   = off_up[4:0];
            s.legal = ({24'd0, off_up} < channels);
        end
        return s;
    endfunction

endpackage

// File: rtl/cat_status_ctrl_if.sv
// ---------------------------------------------------------------------------
// cat_status_ctrl_if
//   Byte stream handshake from the UART receiver into the command decoder.
//   byte_in    : received byte
//   byte_valid : byte_in is valid this cycle (driven by master)
//   byte_ready : decoder accepts byte_in this cycle (driven by slave)
// ---------------------------------------------------------------------------
interface cat_status_ctrl_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input  byte_ready);
    modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
//   Free-running counter 0..PERIOD-1; tick is high for one cycle at the
//   terminal count, so ticks arrive every PERIOD cycles.
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : terminal-count pulse
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == CNT_LAST);
endmodule

// File: rtl/cat_status_ctrl.sv
// ---------------------------------------------------------------------------
// cat_status_ctrl
//   UART command decoder and status register for the badge LED channels.
//   Letters set ('a'+i) or clear ('A'+i) channel i, '*' / '-' act on all
//   channels, '~' / '@' take a letter argument to toggle status / blink
//   enable. A missing argument times out after ARG_TIMEOUT cycles.
//   clk, reset_n : clock, asynchronous active-low reset
//   rx           : byte handshake (slave side)
//   status       : per-channel status bits
//   blink_en     : per-channel blink enables
//   led_out      : status gated by the blink phase
//   cmd_err      : one-cycle pulse per bad byte or argument timeout
//   cmd_count    : executed command count, wraps at 16 bits
// ---------------------------------------------------------------------------
module cat_status_ctrl
    import cat_cmd_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int CLK_FREQ    = 103_340_000,
    parameter int BLINK_HZ    = 2,
    parameter int ARG_TIMEOUT = CLK_FREQ / 100,
    parameter logic [CHANNELS-1:0] RESET_STATUS = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                reset_n,
    cat_status_ctrl_if.slave    rx,
    output logic [CHANNELS-1:0] status,
    output logic [CHANNELS-1:0] blink_en,
    output logic [CHANNELS-1:0] led_out,
    output logic                cmd_err,
    output logic [15:0]         cmd_count
);
    localparam int BLINK_PERIOD = (CLK_FREQ / (2 * BLINK_HZ) > 0) ? CLK_FREQ / (2 * BLINK_HZ) : 1;
    localparam int TMR_W        = (ARG_TIMEOUT > 2) ? $clog2(ARG_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARG_TIMEOUT - 1);

    cmd_state_e          state_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic [CHANNELS-1:0] status_reg;
    logic [CHANNELS-1:0] blink_en_reg;
    logic                err_reg;
    logic [15:0]         count_reg;
    logic                ready_reg;
    logic                phase_reg;
    logic                blink_tick;
    logic                accept;
    chan_sel_t           sel;
    logic [CHANNELS-1:0] chan_mask;

    assign accept = rx.byte_valid && ready_reg;
    assign sel    = decode_chan(rx.byte_in, CHANNELS);

    // One-hot mask of the addressed channel; all zero for an illegal index.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
            assign chan_mask[gi] = sel.legal && (sel.idx == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= '0;
            status_reg   <= RESET_STATUS;
            blink_en_reg <= '0;
            err_reg      <= 1'b0;
            count_reg    <= '0;
            ready_reg    <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (sel.legal) begin
                            if (sel.upper) status_reg <= status_reg & ~chan_mask;
                            else           status_reg <= status_reg | chan_mask;
                            count_reg <= count_reg + 16'd1;
                        end else begin
                            case (rx.byte_in)
                                CMD_ALL_SET: begin
                                    status_reg <= '1;
                                    count_reg  <= count_reg + 16'd1;
                                end
                                CMD_ALL_CLR: begin
                                    status_reg   <= '0;
                                    blink_en_reg <= '0;
                                    count_reg    <= count_reg + 16'd1;
                                end
                                CMD_TOG: begin
                                    state_reg <= ST_ARG_TOG;
                                    timer_reg <= '0;
                                end
                                CMD_BLK: begin
                                    state_reg <= ST_ARG_BLK;
                                    timer_reg <= '0;
                                end
                                CHR_CR, CHR_LF: ;
                                default: err_reg <= 1'b1;
                            endcase
                        end
                    end
                end
                ST_ARG_TOG, ST_ARG_BLK: begin
                    // An accepted argument takes priority over a coincident timeout.
                    if (accept) begin
                        state_reg <= ST_IDLE;
                        if (sel.legal) begin
                            if (state_reg == ST_ARG_TOG) status_reg   <= status_reg ^ chan_mask;
                            else                         blink_en_reg <= blink_en_reg ^ chan_mask;
                            count_reg <= count_reg + 16'd1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else if (timer_reg == TMR_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    tick_divider #(
        .PERIOD (BLINK_PERIOD)
    ) u_blink_div (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (blink_tick)
    );

    // Blink phase runs regardless of the command parser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        phase_reg <= 1'b1;
        else if (blink_tick) phase_reg <= ~phase_reg;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_led
            assign led_out[gi] = status_reg[gi] & (~blink_en_reg[gi] | phase_reg);
        end
    endgenerate

    assign rx.byte_ready = ready_reg;
    assign status        = status_reg;
    assign blink_en      = blink_en_reg;
    assign cmd_err       = err_reg;
    assign cmd_count     = count_reg;
endmodule
